// File: rtl/ldl_wrr_burst_arb.sv
//==============================================================================
// Module      : ldl_wrr_burst_arb
// Description : Weighted round-robin arbiter that locks the grant for whole
//               bursts and lets a winner keep the port for up to wgt[i] bursts.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module ldl_wrr_burst_arb #(
    parameter int BIN_WIDTH = 3,
    parameter int REQ_WIDTH = 1 << BIN_WIDTH,
    parameter int WGT_WIDTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [REQ_WIDTH-1:0]           req,
    input  logic [REQ_WIDTH-1:0]           last,
    input  logic [REQ_WIDTH*WGT_WIDTH-1:0] wgt,
    input  logic                           rdy,
    output logic [REQ_WIDTH-1:0]           gnt,
    output logic [BIN_WIDTH-1:0]           gnt_bin,
    output logic                           busy,
    output logic                           fire,
    output logic [BIN_WIDTH-1:0]           pre_bin
);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_BUSY = 1'b1;

    logic [0:0]           r_state,   w_state_nxt;
    logic [REQ_WIDTH-1:0] r_gnt,     w_gnt_nxt;
    logic [BIN_WIDTH-1:0] r_gnt_bin, w_gnt_bin_nxt;
    logic [BIN_WIDTH-1:0] r_pre_bin, w_pre_bin_nxt;
    logic [WGT_WIDTH-1:0] r_credit,  w_credit_nxt;
    logic                 r_mid,     w_mid_nxt;

    logic                 w_found;
    logic [BIN_WIDTH-1:0] w_winner;
    logic [WGT_WIDTH-1:0] w_quota;
    logic                 w_fire;
    logic                 w_release;

    // Rotating search starting just after the last released winner;
    // index arithmetic wraps naturally because REQ_WIDTH == 2**BIN_WIDTH.
    always_comb begin
        logic [BIN_WIDTH-1:0] w_idx;
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int k = 0; k < REQ_WIDTH; k++) begin
            w_idx = r_pre_bin + BIN_WIDTH'(k + 1);
            if (!w_found && req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    always_comb begin
        w_quota = wgt[w_winner*WGT_WIDTH +: WGT_WIDTH];
        if (w_quota == '0) begin
            w_quota = WGT_WIDTH'(1);
        end
    end

    assign w_fire = (r_state == c_BUSY) && req[r_gnt_bin] && rdy;

    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_nxt     = r_gnt;
        w_gnt_bin_nxt = r_gnt_bin;
        w_pre_bin_nxt = r_pre_bin;
        w_credit_nxt  = r_credit;
        w_mid_nxt     = r_mid;
        w_release     = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_found) begin
                    w_state_nxt   = c_BUSY;
                    w_gnt_nxt     = REQ_WIDTH'(1) << w_winner;
                    w_gnt_bin_nxt = w_winner;
                    w_credit_nxt  = w_quota;
                    w_mid_nxt     = 1'b0;
                end
            end
            c_BUSY: begin
                if (w_fire && last[r_gnt_bin]) begin
                    w_mid_nxt    = 1'b0;
                    w_credit_nxt = r_credit - WGT_WIDTH'(1);
                    w_release    = (r_credit == WGT_WIDTH'(1));
                end else if (w_fire) begin
                    w_mid_nxt = 1'b1;
                end else if (!r_mid && !req[r_gnt_bin]) begin
                    w_release = 1'b1;
                end
                if (w_release) begin
                    w_state_nxt   = c_IDLE;
                    w_gnt_nxt     = '0;
                    w_pre_bin_nxt = r_gnt_bin;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= c_IDLE;
            r_gnt     <= '0;
            r_gnt_bin <= '0;
            r_pre_bin <= '1;
            r_credit  <= '0;
            r_mid     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_gnt     <= w_gnt_nxt;
            r_gnt_bin <= w_gnt_bin_nxt;
            r_pre_bin <= w_pre_bin_nxt;
            r_credit  <= w_credit_nxt;
            r_mid     <= w_mid_nxt;
        end
    end

    assign gnt     = r_gnt;
    assign gnt_bin = r_gnt_bin;
    assign busy    = (r_state == c_BUSY);
    assign fire    = w_fire;
    assign pre_bin = r_pre_bin;

endmodule

`default_nettype wire

// File: tb/tb_ldl_wrr_burst_arb.sv
//==============================================================================
// Module      : tb_ldl_wrr_burst_arb
// Description : Directed bench with a cycle model of the arbiter's rules.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_ldl_wrr_burst_arb;

    localparam int BIN_WIDTH = 3;
    localparam int REQ_WIDTH = 8;
    localparam int WGT_WIDTH = 4;

    logic                           clk = 1'b0;
    logic                           rst_n;
    logic [REQ_WIDTH-1:0]           req;
    logic [REQ_WIDTH-1:0]           last;
    logic [REQ_WIDTH*WGT_WIDTH-1:0] wgt;
    logic                           rdy;
    logic [REQ_WIDTH-1:0]           gnt;
    logic [BIN_WIDTH-1:0]           gnt_bin;
    logic                           busy;
    logic                           fire;
    logic [BIN_WIDTH-1:0]           pre_bin;

    int errors = 0;
    int checks = 0;

    ldl_wrr_burst_arb #(
        .BIN_WIDTH(BIN_WIDTH),
        .REQ_WIDTH(REQ_WIDTH),
        .WGT_WIDTH(WGT_WIDTH)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .last   (last),
        .wgt    (wgt),
        .rdy    (rdy),
        .gnt    (gnt),
        .gnt_bin(gnt_bin),
        .busy   (busy),
        .fire   (fire),
        .pre_bin(pre_bin)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: owner, bursts completed so far against the quota
    // captured at grant time, and whether the owner is inside a burst.
    bit m_valid  = 1'b0;
    bit m_busy   = 1'b0;
    int m_owner  = 0;
    int m_ptr    = 7;
    int m_quota  = 0;
    int m_done   = 0;
    bit m_inside = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_valid  = 1'b1;
            m_busy   = 1'b0;
            m_owner  = 0;
            m_ptr    = REQ_WIDTH - 1;
            m_done   = 0;
            m_inside = 1'b0;
        end else if (m_valid) begin
            if (!m_busy) begin
                for (int k = 1; k <= REQ_WIDTH; k++) begin
                    if (!m_busy && req[(m_ptr + k) % REQ_WIDTH]) begin
                        m_busy   = 1'b1;
                        m_owner  = (m_ptr + k) % REQ_WIDTH;
                        m_quota  = int'(wgt[m_owner*WGT_WIDTH +: WGT_WIDTH]);
                        if (m_quota == 0) m_quota = 1;
                        m_done   = 0;
                        m_inside = 1'b0;
                    end
                end
            end else begin
                if (req[m_owner] && rdy) begin
                    if (last[m_owner]) begin
                        m_inside = 1'b0;
                        m_done++;
                        if (m_done >= m_quota) begin
                            m_busy = 1'b0;
                            m_ptr  = m_owner;
                        end
                    end else begin
                        m_inside = 1'b1;
                    end
                end else if (!m_inside && !req[m_owner]) begin
                    m_busy = 1'b0;
                    m_ptr  = m_owner;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_gnt",     int'(gnt),     m_busy ? (1 << m_owner) : 0);
            check("model_gnt_bin", int'(gnt_bin), m_owner);
            check("model_busy",    int'(busy),    int'(m_busy));
            check("model_pre_bin", int'(pre_bin), m_ptr);
            check("model_fire",    int'(fire),    int'(m_busy && req[m_owner] && rdy));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wgt(input int idx, input int val);
        wgt[idx*WGT_WIDTH +: WGT_WIDTH] = WGT_WIDTH'(val);
    endtask

    // Take one grant from IDLE and count single-beat bursts until release.
    task automatic run_grant(input int exp_bin, input int exp_bursts);
        int n;
        tick();
        check("grant_bin",  int'(gnt_bin), exp_bin);
        check("grant_busy", int'(busy), 1);
        n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        check("grant_bursts", n, exp_bursts);
    endtask

    initial begin
        int order2 [6] = '{2, 5, 7, 2, 5, 7};

        rst_n = 1'b0;
        req   = 8'hFF;
        last  = 8'h00;
        rdy   = 1'b1;
        wgt   = '0;
        for (int i = 0; i < REQ_WIDTH; i++) set_wgt(i, 1);

        // Reset state and pointer wrap 7 -> 0
        tick();
        tick();
        check("rst_gnt",     int'(gnt), 0);
        check("rst_busy",    int'(busy), 0);
        check("rst_pre_bin", int'(pre_bin), 7);
        rst_n = 1'b1;
        tick();
        check("wrap_gnt", int'(gnt), 8'h01);
        req = 8'h00;
        tick();
        check("idle_release", int'(busy), 0);
        check("idle_pre_bin", int'(pre_bin), 0);

        // Fairness
        req  = 8'b1010_0100;
        last = 8'hFF;
        for (int g = 0; g < 6; g++) run_grant(order2[g], 1);
        req = 8'h00;

        // Weighting
        set_wgt(1, 3);
        set_wgt(3, 1);
        req = 8'h0A;
        run_grant(1, 3);
        run_grant(3, 1);
        run_grant(1, 3);
        req = 8'h00;
        tick();

        // Backpressure on a 4-beat burst
        req  = 8'h40;
        last = 8'h00;
        tick();
        check("bp_gnt", int'(gnt), 8'h40);
        tick();
        tick();
        rdy = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("bp_hold_gnt", int'(gnt), 8'h40);
            check("bp_hold_fire", int'(fire), 0);
        end
        rdy = 1'b1;
        tick();
        check("bp_beat3_busy", int'(busy), 1);
        last = 8'h40;
        tick();
        check("bp_release", int'(busy), 0);
        check("bp_pre_bin", int'(pre_bin), 6);
        req  = 8'h00;
        last = 8'h00;

        // Early release, then search resumes from 5
        set_wgt(4, 4);
        req  = 8'h10;
        last = 8'h10;
        tick();
        check("early_gnt", int'(gnt), 8'h10);
        tick();
        req = 8'h00;
        tick();
        check("early_busy", int'(busy), 0);
        check("early_pre_bin", int'(pre_bin), 4);
        req  = 8'h11;
        last = 8'h11;
        tick();
        check("early_next_gnt", int'(gnt), 8'h01);
        req = 8'h00;
        tick();

        // Zero weight acts as one burst
        set_wgt(2, 0);
        req  = 8'h04;
        last = 8'h04;
        run_grant(2, 1);
        req = 8'h00;

        // Reset in the middle of a burst
        req  = 8'h08;
        last = 8'h00;
        tick();
        check("mid_gnt", int'(gnt), 8'h08);
        tick();
        rst_n = 1'b0;
        tick();
        check("mid_rst_gnt", int'(gnt), 0);
        check("mid_rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        req   = 8'h0C;
        tick();
        check("post_rst_bin", int'(gnt_bin), 2);
        req = 8'h00;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
